// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh engine: interval timer, postponed-refresh credits,
// and a PRECHARGE-ALL + AUTO-REFRESH burst sequencer for the arbiter.
module sdram_aref_ctrl #(
    parameter int CNT_REF_MAX = 749,
    parameter int AREF_NUM    = 2,
    parameter int TRP_CLK     = 3,
    parameter int TRFC_CLK    = 8,
    parameter int MAX_PEND    = 8,
    parameter int URGENT_TH   = 6,
    parameter int ADDR_W      = 13,
    parameter int BA_W        = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic              aref_en,
    output logic              aref_req,
    output logic              aref_urgent,
    output logic [3:0]        aref_cmd,
    output logic [BA_W-1:0]   aref_ba,
    output logic [ADDR_W-1:0] aref_addr,
    output logic              aref_end,
    output logic [3:0]        pend_cnt,
    output logic              ovf_err
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PCH = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam int CNT_W  = $clog2(CNT_REF_MAX + 1);
    localparam int WAIT_W = $clog2(TRP_CLK + TRFC_CLK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCH,
        S_TRP,
        S_AREF,
        S_TRF,
        S_END
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic [3:0]        r_ref;
    logic [3:0]        r_pend;
    logic              r_ovf;
    logic              r_req;
    logic [3:0]        r_cmd;

    logic              w_tick;
    logic              w_end;
    logic              w_grant;
    logic              w_last;
    logic              w_wait_exp;
    logic              w_in_wait;
    logic [3:0]        w_pend_nxt;
    logic              w_ovf_set;
    logic              w_req_nxt;

    assign w_tick  = init_end && (r_cnt == CNT_W'(CNT_REF_MAX));
    assign w_end   = (r_state == S_END);
    assign w_grant = (r_state == S_IDLE) && r_req && aref_en && init_end;
    assign w_last  = (r_ref == 4'(AREF_NUM));

    // The wait after the final A_REF is one cycle longer than the
    // inter-refresh wait because END itself carries aref_end.
    assign w_in_wait  = (r_state == S_TRP) || (r_state == S_TRF);
    assign w_wait_exp =
        ((r_state == S_TRP) && (r_wait == WAIT_W'(TRP_CLK - 2))) ||
        ((r_state == S_TRF) && w_last &&
         (r_wait == WAIT_W'(TRFC_CLK - 1))) ||
        ((r_state == S_TRF) && !w_last &&
         (r_wait == WAIT_W'(TRFC_CLK - 2)));

    assign aref_req    = r_req;
    assign aref_urgent = (r_pend >= 4'(URGENT_TH));
    assign aref_cmd    = r_cmd;
    assign aref_ba     = {BA_W{1'b1}};
    assign aref_addr   = {ADDR_W{1'b1}};
    assign aref_end    = w_end;
    assign pend_cnt    = r_pend;
    assign ovf_err     = r_ovf;

    // Refresh interval counter, held at zero until init completes
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_cnt <= '0;
        else if (!init_end || w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Next credit count: tick and session end cancel each other
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_set  = 1'b0;
        if (w_tick && !w_end) begin
            if (r_pend == 4'(MAX_PEND))
                w_ovf_set = 1'b1;
            else
                w_pend_nxt = r_pend + 4'd1;
        end else if (w_end && !w_tick && (r_pend != 4'd0)) begin
            w_pend_nxt = r_pend - 4'd1;
        end
    end

    // Credit and sticky overflow registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pend <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovf  <= r_ovf | w_ovf_set;
        end
    end

    // Request: from IDLE on held credits, from END on remaining ones
    always_comb begin
        w_req_nxt = 1'b0;
        unique case (r_state)
            S_IDLE:  w_req_nxt = (r_pend != 4'd0) && !w_grant;
            S_END:   w_req_nxt = (w_pend_nxt != 4'd0);
            default: w_req_nxt = 1'b0;
        endcase
    end

    // Registered request to the arbiter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_req <= 1'b0;
        else
            r_req <= w_req_nxt;
    end

    // Session state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Session next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_PCH;
            S_PCH:  w_state_nxt = S_TRP;
            S_TRP:  if (w_wait_exp) w_state_nxt = S_AREF;
            S_AREF: w_state_nxt = S_TRF;
            S_TRF: begin
                if (w_wait_exp)
                    w_state_nxt = w_last ? S_END : S_AREF;
            end
            S_END:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait counter, cleared on each wait exit and outside waits
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_wait <= '0;
        else if (w_in_wait && !w_wait_exp)
            r_wait <= r_wait + 1'b1;
        else
            r_wait <= '0;
    end

    // Per-session refresh counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_ref <= 4'd0;
        else if (r_state == S_IDLE)
            r_ref <= 4'd0;
        else if (r_state == S_AREF)
            r_ref <= r_ref + 4'd1;
    end

    // Command register, one cycle behind the state
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_cmd <= CMD_NOP;
        else if (r_state == S_PCH)
            r_cmd <= CMD_PCH;
        else if (r_state == S_AREF)
            r_cmd <= CMD_REF;
        else
            r_cmd <= CMD_NOP;
    end

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Bench for sdram_aref_ctrl: three parameter sets against a
// session-timeline reference model under random arbiter grants.
module tb_sdram_aref_ctrl;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic        en      [NI];
    logic        req     [NI];
    logic        urg     [NI];
    logic [3:0]  cmd     [NI];
    logic [1:0]  ba      [NI];
    logic [12:0] addr    [NI];
    logic        aend    [NI];
    logic [3:0]  pend    [NI];
    logic        ovf     [NI];

    int n_vec = 0;
    int n_err = 0;

    int m_pend [NI];
    int m_ovf  [NI];
    int m_req  [NI];
    int m_busy [NI];
    int m_rel  [NI];
    int m_run  [NI];
    int prob   [NI];
    logic nxt_rst;
    logic nxt_init;

    always #5 clk = ~clk;

    sdram_aref_ctrl #(.CNT_REF_MAX(9)) u0 (
        .sys_clk(clk), .sys_rst(rst), .init_end(init_end),
        .aref_en(en[0]), .aref_req(req[0]), .aref_urgent(urg[0]),
        .aref_cmd(cmd[0]), .aref_ba(ba[0]), .aref_addr(addr[0]),
        .aref_end(aend[0]), .pend_cnt(pend[0]), .ovf_err(ovf[0])
    );

    sdram_aref_ctrl #(
        .CNT_REF_MAX(19), .AREF_NUM(1), .TRP_CLK(2), .TRFC_CLK(5)
    ) u1 (
        .sys_clk(clk), .sys_rst(rst), .init_end(init_end),
        .aref_en(en[1]), .aref_req(req[1]), .aref_urgent(urg[1]),
        .aref_cmd(cmd[1]), .aref_ba(ba[1]), .aref_addr(addr[1]),
        .aref_end(aend[1]), .pend_cnt(pend[1]), .ovf_err(ovf[1])
    );

    sdram_aref_ctrl #(
        .CNT_REF_MAX(29), .AREF_NUM(4), .TRP_CLK(2), .TRFC_CLK(5)
    ) u2 (
        .sys_clk(clk), .sys_rst(rst), .init_end(init_end),
        .aref_en(en[2]), .aref_req(req[2]), .aref_urgent(urg[2]),
        .aref_cmd(cmd[2]), .aref_ba(ba[2]), .aref_addr(addr[2]),
        .aref_end(aend[2]), .pend_cnt(pend[2]), .ovf_err(ovf[2])
    );

    function automatic int p_c(int i);
        return (i == 0) ? 9 : (i == 1) ? 19 : 29;
    endfunction
    function automatic int p_n(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction
    function automatic int p_trp(int i);
        return (i == 0) ? 3 : 2;
    endfunction
    function automatic int p_trfc(int i);
        return (i == 0) ? 8 : 5;
    endfunction
    function automatic int end_rel(int i);
        return 2 + p_trp(i) + p_n(i) * p_trfc(i);
    endfunction

    // Command expected on the bus, from cycles elapsed since the grant
    function automatic logic [3:0] exp_cmd(int i);
        int d;
        if (m_busy[i] == 0) return 4'b0111;
        if (m_rel[i] == 2) return 4'b0010;
        d = m_rel[i] - 2 - p_trp(i);
        if (d >= 0 && (d % p_trfc(i)) == 0 && (d / p_trfc(i)) < p_n(i))
            return 4'b0001;
        return 4'b0111;
    endfunction

    function automatic logic exp_end(int i);
        return (m_busy[i] != 0) && (m_rel[i] == end_rel(i));
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs,
                       logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed %0h expected %0h t=%0t",
                   tag, i, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_req[i] = 0;
            m_busy[i] = 0; m_rel[i] = 0; m_run[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("cmd", i, 32'(cmd[i]), 32'(exp_cmd(i)));
            chk("req", i, 32'(req[i]), 32'(m_req[i] != 0));
            chk("urgent", i, 32'(urg[i]), 32'(m_pend[i] >= 6));
            chk("end", i, 32'(aend[i]), 32'(exp_end(i)));
            chk("pend", i, 32'(pend[i]), 32'(m_pend[i]));
            chk("ovf", i, 32'(ovf[i]), 32'(m_ovf[i]));
            chk("ba", i, 32'(ba[i]), 32'h3);
            chk("addr", i, 32'(addr[i]), 32'h1fff);
        end
    endtask

    // Advance the model across the coming clock edge
    task automatic model_step();
        int  pn, ovn, rqn;
        bit  gnt, ev, tk;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            gnt = (m_busy[i] == 0) && (m_req[i] != 0) && en[i] && init_end;
            ev  = exp_end(i);
            tk  = init_end && ((m_run[i] % (p_c(i) + 1)) == p_c(i));
            pn  = m_pend[i];
            ovn = m_ovf[i];
            if (tk && !ev) begin
                if (pn == 8) ovn = 1;
                else pn = pn + 1;
            end else if (ev && !tk && pn > 0) begin
                pn = pn - 1;
            end
            if (gnt) rqn = 0;
            else if (m_busy[i] == 0) rqn = (m_pend[i] != 0);
            else if (ev) rqn = (pn != 0);
            else rqn = 0;
            m_run[i] = init_end ? m_run[i] + 1 : 0;
            if (gnt) begin
                m_busy[i] = 1; m_rel[i] = 1;
            end else if (ev) begin
                m_busy[i] = 0; m_rel[i] = 0;
            end else if (m_busy[i] != 0) begin
                m_rel[i] = m_rel[i] + 1;
            end
            m_pend[i] = pn;
            m_ovf[i]  = ovn;
            m_req[i]  = rqn;
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
            rst      = nxt_rst;
            init_end = nxt_init;
            for (int i = 0; i < NI; i++)
                en[i] = ($urandom_range(99) < prob[i]);
            model_step();
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        init_end = 1'b0;
        nxt_rst = 1'b1;
        nxt_init = 1'b0;
        for (int i = 0; i < NI; i++) begin
            en[i] = 1'b0;
            prob[i] = 0;
        end
        model_reset();

        // reset, then idle with init incomplete
        run(3);
        nxt_rst = 1'b0;
        run(100);

        // first tick, then random grants
        nxt_init = 1'b1;
        run(15);
        for (int i = 0; i < NI; i++) prob[i] = 40;
        run(300);

        // postpone everything: urgency, saturation, overflow
        for (int i = 0; i < NI; i++) prob[i] = 0;
        run(140);
        for (int i = 0; i < NI; i++) prob[i] = 100;
        run(250);

        // async reset inside the TRF wait of instance 0
        for (int i = 0; i < NI; i++) prob[i] = 30;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            run(1);
            if (m_busy[0] != 0 && m_rel[0] == 8) found = 1'b1;
        end
        chk("trf_reached", 0, 32'(found), 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        nxt_rst = 1'b1;
        run(3);
        nxt_rst = 1'b0;
        for (int i = 0; i < NI; i++) prob[i] = 50;
        run(300);

        // init_end drop mid-run, then recovery
        nxt_init = 1'b0;
        run(60);
        nxt_init = 1'b1;
        run(150);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
